// File: rtl/safe_lock_ctrl.sv
// -----------------------------------------------------------------------------
// safe_lock_ctrl
// Password-check and lockout controller for the 4-bit safe box.
//
// An entered code is compared against the stored password. A match opens the
// safe. A mismatch produces a one-cycle `wrong` pulse and bumps the
// consecutive-error counter. When the counter reaches MAX_ERR the controller
// enters ALARM. ALARM is left by `admin_clr` or by the ALARM_CYCLES timeout.
// While the safe is open, `set_req` arms SET_WAIT, and the next valid key in
// SET_WAIT becomes the new password. OPEN and SET_WAIT both relock
// automatically after UNLOCK_CYCLES cycles.
//
// Ports
//   clk_i        system clock (single domain)
//   rst_i        synchronous active-high reset
//   key_i        entered 4-bit code, sampled only when key_valid_i = 1
//   key_valid_i  one-cycle strobe: key_i holds a complete entry
//   lock_req_i   relock now (level or pulse)
//   set_req_i    pulse: the next valid key becomes the password
//   admin_clr_i  pulse: clear the alarm and return to LOCKED
//   unlock_o     registered, 1 in OPEN and SET_WAIT
//   alarm_o      registered, 1 in ALARM (drives the alarm LED/buzzer driver)
//   wrong_o      registered one-cycle pulse per rejected entry
//   err_cnt_o    registered consecutive-wrong counter
//   state_o      current FSM state (debug observation)
//
// Handshake: key_valid_i is a strobe with no back-pressure. Every cycle in
// which it is high is one complete entry. That entry is evaluated against the
// state left by the previous cycle, so back-to-back strobes are each honoured.
// -----------------------------------------------------------------------------
module safe_lock_ctrl #(
   parameter logic [3:0]  DEFAULT_PWD   = 4'h0,
   parameter int          MAX_ERR       = 3,
   parameter logic [23:0] UNLOCK_CYCLES = 24'd8_000_000,
   parameter logic [23:0] ALARM_CYCLES  = 24'd16_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] key_i,
   input  logic       key_valid_i,
   input  logic       lock_req_i,
   input  logic       set_req_i,
   input  logic       admin_clr_i,
   output logic       unlock_o,
   output logic       alarm_o,
   output logic       wrong_o,
   output logic [1:0] err_cnt_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      S_LOCKED   = 2'd0,
      S_OPEN     = 2'd1,
      S_SET_WAIT = 2'd2,
      S_ALARM    = 2'd3
   } state_t;

   localparam logic [2:0]  MAX_ERR_W  = 3'(MAX_ERR);
   localparam logic [1:0]  MAX_ERR_C  = 2'(MAX_ERR);
   localparam logic [23:0] UNLOCK_END = UNLOCK_CYCLES - 24'd1;
   localparam logic [23:0] ALARM_END  = ALARM_CYCLES - 24'd1;

   state_t      state_q,   state_d;
   logic [3:0]  pwd_q,     pwd_d;
   logic [1:0]  err_cnt_q, err_cnt_d;
   logic [23:0] timer_q,   timer_d;
   logic        wrong_q,   wrong_d;
   logic        unlock_q;
   logic        alarm_q;

   always_comb begin
      state_d   = state_q;
      pwd_d     = pwd_q;
      err_cnt_d = err_cnt_q;
      timer_d   = timer_q;
      wrong_d   = 1'b0;

      unique case (state_q)
         S_LOCKED: begin
            if (key_valid_i) begin
               if (key_i == pwd_q) begin
                  state_d   = S_OPEN;
                  err_cnt_d = 2'd0;
                  timer_d   = 24'd0;
               end else begin
                  wrong_d = 1'b1;
                  // The compare is 3 bits wide so err_cnt+1 cannot wrap.
                  if (({1'b0, err_cnt_q} + 3'd1) == MAX_ERR_W) begin
                     state_d   = S_ALARM;
                     err_cnt_d = MAX_ERR_C;
                     timer_d   = 24'd0;
                  end else begin
                     err_cnt_d = err_cnt_q + 2'd1;
                  end
               end
            end
         end

         S_OPEN: begin
            timer_d = timer_q + 24'd1;
            if (lock_req_i || (timer_q == UNLOCK_END)) begin
               state_d = S_LOCKED;
               timer_d = 24'd0;
            end else if (set_req_i) begin
               state_d = S_SET_WAIT;
               timer_d = 24'd0;
            end
         end

         S_SET_WAIT: begin
            timer_d = timer_q + 24'd1;
            if (lock_req_i || (timer_q == UNLOCK_END)) begin
               state_d = S_LOCKED;
               timer_d = 24'd0;
            end else if (key_valid_i) begin
               pwd_d   = key_i;
               state_d = S_OPEN;
               timer_d = 24'd0;
            end
         end

         S_ALARM: begin
            timer_d = timer_q + 24'd1;
            if (admin_clr_i || (timer_q == ALARM_END)) begin
               state_d   = S_LOCKED;
               err_cnt_d = 2'd0;
               timer_d   = 24'd0;
            end
         end

         default: begin
            state_d = S_LOCKED;
            timer_d = 24'd0;
         end
      endcase
   end

   // unlock/alarm are decoded from the next state, so they change on the
   // same edge that changes the state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_LOCKED;
         pwd_q     <= DEFAULT_PWD;
         err_cnt_q <= 2'd0;
         timer_q   <= 24'd0;
         wrong_q   <= 1'b0;
         unlock_q  <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pwd_q     <= pwd_d;
         err_cnt_q <= err_cnt_d;
         timer_q   <= timer_d;
         wrong_q   <= wrong_d;
         unlock_q  <= (state_d == S_OPEN) || (state_d == S_SET_WAIT);
         alarm_q   <= (state_d == S_ALARM);
      end
   end

   assign unlock_o  = unlock_q;
   assign alarm_o   = alarm_q;
   assign wrong_o   = wrong_q;
   assign err_cnt_o = err_cnt_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_safe_lock_ctrl
// Directed bench for safe_lock_ctrl with DEFAULT_PWD=4'hA, MAX_ERR=3,
// UNLOCK_CYCLES=20, ALARM_CYCLES=50. Inputs change 1 time unit after a rising
// edge. Outputs are checked 1 time unit after the edge that updated them.
// -----------------------------------------------------------------------------
module tb_safe_lock_ctrl;

   localparam logic [1:0] ST_LOCKED   = 2'd0;
   localparam logic [1:0] ST_OPEN     = 2'd1;
   localparam logic [1:0] ST_SET_WAIT = 2'd2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key = 4'h0;
   logic       key_valid = 1'b0;
   logic       lock_req = 1'b0;
   logic       set_req = 1'b0;
   logic       admin_clr = 1'b0;
   logic       unlock;
   logic       alarm;
   logic       wrong;
   logic [1:0] err_cnt;
   logic [1:0] state;

   int n_cmp  = 0;
   int n_fail = 0;

   // clock / reset block
   always #5 clk = ~clk;

   safe_lock_ctrl #(
      .DEFAULT_PWD   (4'hA),
      .MAX_ERR       (3),
      .UNLOCK_CYCLES (24'd20),
      .ALARM_CYCLES  (24'd50)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .key_i       (key),
      .key_valid_i (key_valid),
      .lock_req_i  (lock_req),
      .set_req_i   (set_req),
      .admin_clr_i (admin_clr),
      .unlock_o    (unlock),
      .alarm_o     (alarm),
      .wrong_o     (wrong),
      .err_cnt_o   (err_cnt),
      .state_o     (state)
   );

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      key       = k;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic u, input logic a,
                          input logic w, input logic [1:0] e);
      chk({tag, ".unlock"},  {31'd0, unlock}, {31'd0, u});
      chk({tag, ".alarm"},   {31'd0, alarm},  {31'd0, a});
      chk({tag, ".wrong"},   {31'd0, wrong},  {31'd0, w});
      chk({tag, ".err_cnt"}, {30'd0, err_cnt}, {30'd0, e});
   endtask

   initial begin
      // Reset
      step();
      step();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 2'd0);
      chk("reset.state", {30'd0, state}, {30'd0, ST_LOCKED});
      rst = 1'b0;

      // Correct key opens for exactly 20 cycles
      press(4'hA);
      chk_all("open", 1'b1, 1'b0, 1'b0, 2'd0);
      for (int i = 1; i < 20; i++) begin
         step();
         chk("open_hold.unlock", {31'd0, unlock}, 32'd1);
      end
      step();
      chk_all("auto_relock", 1'b0, 1'b0, 1'b0, 2'd0);

      // Two wrong keys, then the correct key clears the count
      press(4'h1);
      chk_all("wrong1", 1'b0, 1'b0, 1'b1, 2'd1);
      step();
      chk("wrong1_pulse_end", {31'd0, wrong}, 32'd0);
      press(4'h2);
      chk_all("wrong2", 1'b0, 1'b0, 1'b1, 2'd2);
      press(4'hA);
      chk_all("open_after_wrong", 1'b1, 1'b0, 1'b0, 2'd0);
      lock_req = 1'b1;
      step();
      lock_req = 1'b0;
      chk_all("lock_req", 1'b0, 1'b0, 1'b0, 2'd0);

      // Three back-to-back wrong keys raise the alarm with the third pulse
      press(4'h1);
      chk_all("bb_wrong1", 1'b0, 1'b0, 1'b1, 2'd1);
      press(4'h2);
      chk_all("bb_wrong2", 1'b0, 1'b0, 1'b1, 2'd2);
      press(4'h3);
      chk_all("alarm_on", 1'b0, 1'b1, 1'b1, 2'd3);
      press(4'hA);
      chk_all("alarm_ignore_key", 1'b0, 1'b1, 1'b0, 2'd3);
      for (int i = 2; i < 50; i++) begin
         step();
         chk("alarm_hold", {31'd0, alarm}, 32'd1);
      end
      step();
      chk_all("alarm_timeout", 1'b0, 1'b0, 1'b0, 2'd0);
      chk("alarm_timeout.state", {30'd0, state}, {30'd0, ST_LOCKED});

      // admin_clr in the 10th alarm cycle
      press(4'h1);
      press(4'h2);
      press(4'h3);
      chk("alarm2_on", {31'd0, alarm}, 32'd1);
      for (int i = 1; i < 10; i++) step();
      chk("alarm2_hold", {31'd0, alarm}, 32'd1);
      admin_clr = 1'b1;
      step();
      admin_clr = 1'b0;
      chk_all("admin_clr", 1'b0, 1'b0, 1'b0, 2'd0);
      chk("admin_clr.state", {30'd0, state}, {30'd0, ST_LOCKED});

      // Password change to 4'h5
      press(4'hA);
      chk("pc_open", {31'd0, unlock}, 32'd1);
      set_req = 1'b1;
      step();
      set_req = 1'b0;
      chk("pc_set_wait.state", {30'd0, state}, {30'd0, ST_SET_WAIT});
      chk("pc_set_wait.unlock", {31'd0, unlock}, 32'd1);
      press(4'h5);
      chk("pc_new.state", {30'd0, state}, {30'd0, ST_OPEN});
      chk("pc_new.unlock", {31'd0, unlock}, 32'd1);
      lock_req = 1'b1;
      step();
      lock_req = 1'b0;
      chk("pc_locked.unlock", {31'd0, unlock}, 32'd0);
      press(4'hA);
      chk_all("pc_old_rejected", 1'b0, 1'b0, 1'b1, 2'd1);
      press(4'h5);
      chk_all("pc_new_accepted", 1'b1, 1'b0, 1'b0, 2'd0);

      // lock_req and set_req together in OPEN: lock wins
      lock_req = 1'b1;
      set_req  = 1'b1;
      step();
      lock_req = 1'b0;
      set_req  = 1'b0;
      chk("lock_vs_set.state", {30'd0, state}, {30'd0, ST_LOCKED});
      chk("lock_vs_set.unlock", {31'd0, unlock}, 32'd0);

      // Reset in SET_WAIT after a password change restores 4'hA
      press(4'h5);
      set_req = 1'b1;
      step();
      set_req = 1'b0;
      chk("rst_sw.state_before", {30'd0, state}, {30'd0, ST_SET_WAIT});
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_all("rst_sw", 1'b0, 1'b0, 1'b0, 2'd0);
      chk("rst_sw.state", {30'd0, state}, {30'd0, ST_LOCKED});
      press(4'h5);
      chk_all("rst_pwd_old_rejected", 1'b0, 1'b0, 1'b1, 2'd1);
      press(4'hA);
      chk_all("rst_pwd_default", 1'b1, 1'b0, 1'b0, 2'd0);

      // SET_WAIT timeout relocks and keeps the password
      set_req = 1'b1;
      step();
      set_req = 1'b0;
      for (int i = 1; i < 20; i++) step();
      chk("sw_timeout_hold.unlock", {31'd0, unlock}, 32'd1);
      step();
      chk("sw_timeout.unlock", {31'd0, unlock}, 32'd0);
      chk("sw_timeout.state", {30'd0, state}, {30'd0, ST_LOCKED});
      press(4'hA);
      chk("sw_timeout_pwd_kept", {31'd0, unlock}, 32'd1);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/safe_lock_ctrl.md
# safe_lock_ctrl

Password-check and lockout controller for the 4-bit safe box. It compares entered 4-bit codes against a stored password, drives the unlock output, and counts consecutive wrong entries. After `MAX_ERR` consecutive wrong entries it asserts `alarm`, which feeds the alarm LED/buzzer driver directly downstream. It also supports changing the password while the safe is open.

## Interface
- `DEFAULT_PWD`, default 4'h0: password loaded at reset.
- `MAX_ERR`, default 3: consecutive wrong entries that trigger the alarm. Legal range 1..3.
- `UNLOCK_CYCLES`, default 24'd8_000_000: automatic relock timeout in OPEN/SET_WAIT, in clk cycles. Legal range 1..2^24-1.
- `ALARM_CYCLES`, default 24'd16_000_000: alarm hold time before automatic return to LOCKED. Legal range 1..2^24-1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `key`  in  4  entered code; sampled only when `key_valid`=1.
- `key_valid`  in  1  one-cycle strobe: `key` holds a complete entry.
- `lock_req`  in  1  level/pulse: relock now.
- `set_req`  in  1  pulse: next valid key becomes the new password.
- `admin_clr`  in  1  pulse: clear alarm and return to LOCKED.
- `unlock`  out  1  registered; 1 in OPEN and SET_WAIT.
- `alarm`  out  1  registered; 1 in ALARM. Connects to the alarm driver's `alarm` input.
- `wrong`  out  1  registered one-cycle pulse per rejected entry.
- `err_cnt`  out  2  registered consecutive-wrong counter.

## Operation
- Reset (`rst`=1 at a clk edge): state LOCKED; `pwd`=DEFAULT_PWD; `err_cnt`=0; timer=0; `unlock`=0; `alarm`=0; `wrong`=0. Reset overrides every other input in any state.
- States: LOCKED, OPEN, SET_WAIT, ALARM. `unlock`/`alarm` are decoded from the next-state value and registered, so they reflect the new state on the same edge that enters it.
- LOCKED:
  - `key_valid` with `key`==`pwd` → OPEN; `err_cnt`←0; timer←0.
  - `key_valid` with `key`!=`pwd` → `wrong` pulses.
    - If `err_cnt`+1 == MAX_ERR → ALARM; `err_cnt`←MAX_ERR; timer←0.
    - Otherwise `err_cnt`←`err_cnt`+1.
  - `lock_req`, `set_req` and `admin_clr` are ignored.
- OPEN: timer increments each cycle. Priority, highest first:
  - `lock_req` → LOCKED.
  - timer == UNLOCK_CYCLES-1 → LOCKED.
  - `set_req` → SET_WAIT; timer←0.
  - `key_valid` is ignored.
- SET_WAIT: timer increments each cycle. Priority, highest first:
  - `lock_req` or timeout → LOCKED; `pwd` unchanged.
  - `key_valid` → `pwd`←`key`; go to OPEN; timer←0.
- ALARM: `key_valid`, `lock_req` and `set_req` are ignored, with no `wrong` pulse and no count change.
  - `admin_clr` → LOCKED.
  - timer == ALARM_CYCLES-1 → LOCKED.
  - Exit clears `err_cnt` and timer.
- `wrong` is 0 in every cycle that has no rejected entry.
- `err_cnt` never exceeds MAX_ERR. The stored password survives every state change except reset and a SET_WAIT key.

## Timing
- Key to `unlock`: 1 cycle. `key_valid` at edge N gives `unlock`=1 after edge N.
- Wrong key to `wrong` pulse: 1 cycle; `wrong` is high for exactly 1 cycle. On the triggering wrong key, `alarm` rises in the same cycle as that `wrong` pulse.
- Auto-relock: `unlock` is high for exactly UNLOCK_CYCLES cycles when no other input intervenes.
- Alarm hold: `alarm` is high for exactly ALARM_CYCLES cycles unless `admin_clr` arrives first.
- `admin_clr` at edge N → `alarm`=0 after edge N.
- Back-to-back `key_valid` on consecutive cycles: each strobe is evaluated against the state left by the previous one.
- Alarm driver interface: `alarm` is level-held with no glitches, because it is a flop output. The downstream driver samples it on its divided clock.

## Test plan
Bench parameters: DEFAULT_PWD=4'hA, MAX_ERR=3, UNLOCK_CYCLES=20, ALARM_CYCLES=50.
- Reset, then `key`=4'hA with `key_valid` → `unlock`=1 the next cycle and for 20 cycles, then 0. `err_cnt`=0 throughout.
- Keys 4'h1, 4'h2 → two `wrong` pulses, `err_cnt`=2. Then 4'hA → OPEN, `err_cnt`=0.
- Keys 4'h1, 4'h2, 4'h3 → `alarm`=1 alongside the third `wrong` pulse. Then 4'hA during the alarm → ignored. `alarm` falls after 50 cycles, `err_cnt`=0.
- In ALARM, `admin_clr` at cycle 10 → `alarm`=0 the next cycle, state LOCKED.
- Password change sequence:
  - Open with 4'hA, `set_req`, then key 4'h5 → OPEN with `pwd`=4'h5.
  - `lock_req`, then key 4'hA → `wrong` pulse.
  - Key 4'h5 → `unlock`=1.
- Corner cases:
  - In OPEN, `lock_req` and `set_req` asserted together → LOCKED.
  - `rst` asserted mid-SET_WAIT after a password change → `pwd` returns to 4'hA and all outputs are 0.
